// File: rtl/associate_layer.sv
// associate_layer: a layer of NEUR trainable linear associators that share one
// ARGD-wide unsigned input vector. A single time-multiplexed MAC computes the
// forward weighted sums. When training is enabled, a backward pass takes a
// per-neuron error vector, returns per-input feedback for the upstream layer
// and updates the weights.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   en                   training enable, captured with the input vector
//   arg_valid/ready/data input vector, element i at [i*ARGW +: ARGW]
//   res_valid/ready/data signed result per neuron, RESW bits each
//   err_valid/ready/data signed error per neuron (target - actual)
//   fbk_valid/ready/data signed feedback per input, RESW bits each
//
// Optional feature: define ASSOCIATE_BIAS_EN to add a trainable per-neuron
// bias. This adds one cycle to both the forward and the backward pass.
module associate_layer #(
  parameter int ARGW = 8,
  parameter int ARGD = 2,
  parameter int NEUR = 2,
  parameter int RESW = 16,
  parameter int FRAC = 8,
  parameter int RATE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   arg_valid,
  output logic                   arg_ready,
  input  logic [ARGD*ARGW-1:0]   arg_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NEUR*RESW-1:0]   res_data,
  input  logic                   err_valid,
  output logic                   err_ready,
  input  logic [NEUR*RESW-1:0]   err_data,
  output logic                   fbk_valid,
  input  logic                   fbk_ready,
  output logic [ARGD*RESW-1:0]   fbk_data
);

  localparam int STEPS = NEUR * ARGD;
  localparam int ACCW  = RESW + ARGW + $clog2(ARGD) + 1;
  localparam int FBKW  = 2 * RESW + $clog2(NEUR) + 1;
  localparam int PRDW  = RESW + ARGW + 1;   // signed weight x zero-extended arg
  localparam int BPW   = 2 * RESW;          // signed error x signed weight
  localparam int SATW  = ACCW + FBKW;       // wide enough for every saturated sum
`ifdef ASSOCIATE_BIAS_EN
  localparam int PRE   = 1;                 // cycle 0 of each pass handles the bias
`else
  localparam int PRE   = 0;
`endif
  localparam int LAST  = STEPS + PRE;       // final cycle registers the outputs
  localparam int CW    = $clog2(LAST + 1) + 1;
  localparam int NW    = (NEUR > 1) ? $clog2(NEUR) : 1;
  localparam int IW    = (ARGD > 1) ? $clog2(ARGD) : 1;

  typedef enum logic [2:0] {IDLE, FWD, RES, ERR, BWD, FBK} state_t;

  state_t state, state_nx;

  logic signed [RESW-1:0] weights [NEUR][ARGD];
  logic        [ARGW-1:0] arg_q   [ARGD];
  logic signed [RESW-1:0] err_q   [NEUR];
  logic signed [ACCW-1:0] acc     [NEUR];
  logic signed [FBKW-1:0] fbk_acc [ARGD];
`ifdef ASSOCIATE_BIAS_EN
  logic signed [RESW-1:0] bias    [NEUR];
`endif
  logic          en_q;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n_idx;
  logic [IW-1:0] i_idx;

  logic                   last, mac;
  logic signed [ARGW:0]   arg_x;
  logic signed [RESW-1:0] w_cur, w_new;
  logic signed [PRDW-1:0] fwd_prod, upd_prod;
  logic signed [BPW-1:0]  bwd_prod;

  // Clamp a wide signed value into RESW bits: in range iff every bit above
  // the RESW sign bit matches it.
  function automatic logic signed [RESW-1:0] sat(input logic signed [SATW-1:0] v);
    logic [SATW-RESW:0] hi;
    hi = v[SATW-1:RESW-1];
    if ((&hi) || !(|hi)) return v[RESW-1:0];
    else if (v[SATW-1])  return {1'b1, {(RESW-1){1'b0}}};
    else                 return {1'b0, {(RESW-1){1'b1}}};
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    unique case (state)
      IDLE:    if (arg_valid) state_nx = FWD;
      FWD:     if (last)      state_nx = RES;
      RES:     if (res_ready) state_nx = en_q ? ERR : IDLE;
      ERR:     if (err_valid) state_nx = BWD;
      BWD:     if (last)      state_nx = FBK;
      FBK:     if (fbk_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on the ready inputs
  always_comb begin
    arg_ready = (state == IDLE);
    res_valid = (state == RES);
    err_ready = (state == ERR);
    fbk_valid = (state == FBK);
  end

  // Shared MAC operands for the element selected by (n_idx, i_idx)
  always_comb begin
    last     = (cnt == CW'(LAST));
`ifdef ASSOCIATE_BIAS_EN
    mac      = (cnt != '0) && !last;
`else
    mac      = !last;
`endif
    w_cur    = weights[n_idx][i_idx];
    arg_x    = signed'({1'b0, arg_q[i_idx]});
    fwd_prod = PRDW'(w_cur) * PRDW'(arg_x);
    bwd_prod = BPW'(err_q[n_idx]) * BPW'(w_cur);
    upd_prod = PRDW'(err_q[n_idx]) * PRDW'(arg_x);
    w_new    = sat(SATW'(w_cur) + SATW'(upd_prod >>> (ARGW + RATE)));
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      cnt      <= '0;
      n_idx    <= '0;
      i_idx    <= '0;
      res_data <= '0;
      fbk_data <= '0;
      for (int n = 0; n < NEUR; n++) begin
        acc[n]   <= '0;
        err_q[n] <= '0;
`ifdef ASSOCIATE_BIAS_EN
        bias[n]  <= '0;
`endif
        // NOTE: the weight array is small register storage whose reset value is
        // architecturally visible, so it is cleared here rather than left unreset.
        for (int i = 0; i < ARGD; i++) weights[n][i] <= '0;
      end
      for (int i = 0; i < ARGD; i++) begin
        arg_q[i]   <= '0;
        fbk_acc[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates, so the BWD feedback term reads the
      // pre-update weight even though the same weight is rewritten this cycle.
      unique case (state)
        IDLE: if (arg_valid) begin
          en_q  <= en;
          cnt   <= '0;
          n_idx <= '0;
          i_idx <= '0;
          for (int i = 0; i < ARGD; i++) arg_q[i] <= arg_data[i*ARGW +: ARGW];
          for (int n = 0; n < NEUR; n++) acc[n] <= '0;
        end
        FWD: begin
          cnt <= cnt + 1'b1;
`ifdef ASSOCIATE_BIAS_EN
          if (cnt == '0)
            for (int n = 0; n < NEUR; n++) acc[n] <= ACCW'(bias[n]) <<< FRAC;
`endif
          if (mac) begin
            acc[n_idx] <= acc[n_idx] + ACCW'(fwd_prod);
            if (i_idx == IW'(ARGD - 1)) begin
              i_idx <= '0;
              n_idx <= n_idx + 1'b1;
            end else begin
              i_idx <= i_idx + 1'b1;
            end
          end
          if (last)
            for (int n = 0; n < NEUR; n++)
              res_data[n*RESW +: RESW] <= sat(SATW'(acc[n] >>> FRAC));
        end
        ERR: if (err_valid) begin
          cnt   <= '0;
          n_idx <= '0;
          i_idx <= '0;
          for (int n = 0; n < NEUR; n++) err_q[n] <= err_data[n*RESW +: RESW];
          for (int i = 0; i < ARGD; i++) fbk_acc[i] <= '0;
        end
        BWD: begin
          cnt <= cnt + 1'b1;
`ifdef ASSOCIATE_BIAS_EN
          if (cnt == '0)
            for (int n = 0; n < NEUR; n++)
              bias[n] <= sat(SATW'(bias[n]) + SATW'(err_q[n] >>> RATE));
`endif
          if (mac) begin
            fbk_acc[i_idx]        <= fbk_acc[i_idx] + FBKW'(bwd_prod);
            weights[n_idx][i_idx] <= w_new;
            if (i_idx == IW'(ARGD - 1)) begin
              i_idx <= '0;
              n_idx <= n_idx + 1'b1;
            end else begin
              i_idx <= i_idx + 1'b1;
            end
          end
          if (last)
            for (int i = 0; i < ARGD; i++)
              fbk_data[i*RESW +: RESW] <= sat(SATW'(fbk_acc[i] >>> FRAC));
        end
        default: ;
      endcase
    end
  end

endmodule
